// File: rtl/fetch_warp_scheduler.sv
// Round-robin fetch grant scheduler: one-hot registered grant one cycle after eligibility, one fetch in flight per warp.
// IF stall suppresses the grant and freezes the pointer. FETCH_SCHED_PERF_EN enables the idle-cycle counter.
module fetch_warp_scheduler #(
  parameter int NUM_WARPS = 8,
  parameter int WID_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WARPS-1:0] Active_TM_RR,
  input  logic [NUM_WARPS-1:0] Full_IB_RR,
  input  logic                 Stall_IF_RR,
  input  logic                 FetchDone_IF_RR,
  input  logic [WID_W-1:0]     FetchDoneWid_IF_RR,
  output logic [NUM_WARPS-1:0] GRT_RR_PC,
  output logic                 GrantValid_RR_IF,
  output logic [WID_W-1:0]     GrantWid_RR_IF,
  output logic [31:0]          PerfIdleCnt_RR
);

  logic [WID_W-1:0]     rr_ptr;
  logic [NUM_WARPS-1:0] pending;
  logic [NUM_WARPS-1:0] elig;
  logic [NUM_WARPS-1:0] done_mask;
  logic [NUM_WARPS-1:0] win_onehot;
  logic [NUM_WARPS-1:0] pending_nxt;
  logic [WID_W-1:0]     winner;
  logic [WID_W-1:0]     idx;
  logic                 any_elig;
  logic                 issue;

  assign elig = Active_TM_RR & ~Full_IB_RR & ~pending;

  // Scan from rr_ptr upward; WID_W-bit addition gives the modulo wrap for free.
  always_comb begin
    winner   = rr_ptr;
    any_elig = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = rr_ptr + WID_W'(k);
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        winner   = idx;
      end
    end
  end

  assign issue = ~Stall_IF_RR & any_elig;

  always_comb begin
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
  end

  always_comb begin
    done_mask = '0;
    if (FetchDone_IF_RR)
      done_mask[FetchDoneWid_IF_RR] = 1'b1;
  end

  // The winner is never pending, so clearing and setting cannot collide.
  always_comb begin
    pending_nxt = pending & ~done_mask & Active_TM_RR;
    if (issue)
      pending_nxt = pending_nxt | win_onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr           <= '0;
      pending          <= '0;
      GRT_RR_PC        <= '0;
      GrantValid_RR_IF <= 1'b0;
      GrantWid_RR_IF   <= '0;
    end else begin
      pending          <= pending_nxt;
      GRT_RR_PC        <= issue ? win_onehot : '0;
      GrantValid_RR_IF <= issue;
      if (issue) begin
        GrantWid_RR_IF <= winner;
        rr_ptr         <= winner + WID_W'(1);
      end
    end
  end

`ifdef FETCH_SCHED_PERF_EN
  logic [31:0] idle_cnt;
  logic        idle_cycle;

  assign idle_cycle = ~Stall_IF_RR & ~any_elig & (|Active_TM_RR);

  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt <= '0;
    else if (idle_cycle && idle_cnt != 32'hFFFF_FFFF)
      idle_cnt <= idle_cnt + 32'd1;
  end

  assign PerfIdleCnt_RR = idle_cnt;
`else
  assign PerfIdleCnt_RR = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_warp_scheduler.sv
// Directed and randomized checks of fetch_warp_scheduler against a queue/array level reference model.
module tb_fetch_warp_scheduler;
  localparam int N = 8;
`ifdef FETCH_SCHED_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] active = '0;
  logic [N-1:0] full = '0;
  logic         stall = 1'b0;
  logic         fd = 1'b0;
  logic [2:0]   fdwid = '0;
  logic [N-1:0] grt;
  logic         vld;
  logic [2:0]   wid;
  logic [31:0]  perf;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          m_pend [N];
  int          m_ptr = 0;
  bit          m_vld = 0;
  int          m_wid = 0;
  logic [31:0] m_idle = '0;

  fetch_warp_scheduler #(.NUM_WARPS(N), .WID_W(3)) dut (
    .clk               (clk),
    .rst               (rst),
    .Active_TM_RR      (active),
    .Full_IB_RR        (full),
    .Stall_IF_RR       (stall),
    .FetchDone_IF_RR   (fd),
    .FetchDoneWid_IF_RR(fdwid),
    .GRT_RR_PC         (grt),
    .GrantValid_RR_IF  (vld),
    .GrantWid_RR_IF    (wid),
    .PerfIdleCnt_RR    (perf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the scheduling rules to the inputs present before the coming edge.
  task automatic model_step();
    bit found;
    int win;
    int w;
    if (rst) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_ptr = 0; m_vld = 0; m_wid = 0; m_idle = '0;
      return;
    end
    found = 0; win = 0;
    for (int k = 0; k < N; k++) begin
      w = (m_ptr + k) % N;
      if (!found && active[w] && !full[w] && !m_pend[w]) begin
        found = 1; win = w;
      end
    end
    if (PERF_ON == 1 && !stall && !found && active != 0 && m_idle != 32'hFFFF_FFFF)
      m_idle = m_idle + 1;
    for (int i = 0; i < N; i++)
      if (!active[i] || (fd && int'(fdwid) == i)) m_pend[i] = 0;
    if (stall || !found) begin
      m_vld = 0;
    end else begin
      m_vld = 1; m_wid = win; m_pend[win] = 1; m_ptr = (win + 1) % N;
    end
  endtask

  task automatic compare();
    logic [N-1:0] eg;
    eg = '0;
    if (m_vld) eg[m_wid] = 1'b1;
    chk("grt", 32'(grt), 32'(eg));
    chk("valid", 32'(vld), 32'(m_vld));
    chk("wid", 32'(wid), 32'(m_wid));
    chk("perf", perf, m_idle);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1; fd = 0; stall = 0; active = '0; full = '0;
    cycle();
    chk("rst_grt", 32'(grt), 0);
    chk("rst_valid", 32'(vld), 0);
    chk("rst_perf", perf, 0);
    cycle();
    rst = 0;
  endtask

  initial begin
    int exp5 [7];
    exp5 = '{0, 1, 2, 4, 5, 6, 7};
    for (int i = 0; i < N; i++) m_pend[i] = 0;

    // round robin with FetchDone two cycles after each grant
    do_reset();
    active = 8'hFF;
    for (int e = 1; e <= 9; e++) begin
      fd = (e >= 3);
      fdwid = (e >= 3) ? 3'(e - 3) : 3'd0;
      cycle();
      chk("t1_valid", 32'(vld), 1);
      chk("t1_wid", 32'(wid), 32'((e - 1) % 8));
    end
    fd = 0;

    // two active warps, no FetchDone
    do_reset();
    active = 8'b0010_0100;
    cycle(); chk("t2_grt_a", 32'(grt), 32'h04); chk("t2_wid_a", 32'(wid), 2);
    cycle(); chk("t2_grt_b", 32'(grt), 32'h20); chk("t2_wid_b", 32'(wid), 5);
    for (int c = 0; c < 4; c++) begin
      cycle(); chk("t2_idle_valid", 32'(vld), 0); chk("t2_idle_grt", 32'(grt), 0);
      chk("t2_wid_hold", 32'(wid), 5);
    end

    // stall after the w3 grant
    do_reset();
    active = 8'hFF;
    for (int e = 1; e <= 4; e++) begin
      cycle(); chk("t3_wid", 32'(wid), 32'(e - 1));
    end
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      cycle(); chk("t3_stall_grt", 32'(grt), 0); chk("t3_stall_wid", 32'(wid), 3);
    end
    stall = 0;
    cycle(); chk("t3_resume_valid", 32'(vld), 1); chk("t3_resume_wid", 32'(wid), 4);

    // FetchDone timing and stray FetchDone
    do_reset();
    active = 8'h40;
    cycle(); chk("t4_first", 32'(grt), 32'h40);
    cycle(); cycle(); chk("t4_pending", 32'(vld), 0);
    fd = 1; fdwid = 3'd2;
    cycle(); chk("t4_stray_fd", 32'(vld), 0);
    fdwid = 3'd6;
    cycle(); chk("t4_same_cycle", 32'(vld), 0);
    fd = 0;
    cycle(); chk("t4_regrant_valid", 32'(vld), 1); chk("t4_regrant_wid", 32'(wid), 6);

    // deactivation clears pending
    do_reset();
    active = 8'h02;
    cycle(); chk("t5_grant", 32'(wid), 1);
    cycle(); chk("t5_pending", 32'(vld), 0);
    active = 8'h00;
    cycle(); chk("t5_inactive", 32'(vld), 0);
    active = 8'h02;
    cycle(); chk("t5_regrant_valid", 32'(vld), 1); chk("t5_regrant_wid", 32'(wid), 1);

    // full warp skipped
    do_reset();
    active = 8'hFF; full = 8'h08;
    for (int e = 0; e < 7; e++) begin
      cycle(); chk("t5_full_wid", 32'(wid), 32'(exp5[e]));
    end
    cycle(); chk("t5_full_done", 32'(vld), 0);
    full = '0;

    // idle counter
    do_reset();
    active = 8'h01;
    cycle(); chk("t6_start", perf, 0);
    for (int c = 0; c < 10; c++) cycle();
    chk("t6_count", perf, 32'(10 * PERF_ON));
    rst = 1;
    cycle(); chk("t6_reset", perf, 0);
    rst = 0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int pick;
      if ($urandom_range(0, 199) == 0) rst = 1; else rst = 0;
      if ($urandom_range(0, 19) == 0) active = N'($urandom);
      full = N'($urandom & $urandom & $urandom);
      stall = ($urandom_range(0, 3) == 0);
      fd = 0;
      if ($urandom_range(0, 9) == 0) begin
        fd = 1; fdwid = 3'($urandom);
      end else if ($urandom_range(0, 1) == 0) begin
        pick = $urandom_range(0, N - 1);
        for (int k = 0; k < N; k++)
          if (!fd && m_pend[(pick + k) % N]) begin
            fd = 1; fdwid = 3'((pick + k) % N);
          end
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
